// File: rtl/single_port_ram_ctrl_pkg.sv
// Shared types for the single-port RAM request sequencer.
// State encoding is fixed so waveforms and any external probes stay readable.
package single_port_ram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic OP_WR = 1'b1;
   localparam logic OP_RD = 1'b0;

   function automatic logic is_write(input logic op);
      return op == OP_WR;
   endfunction

endpackage

// File: rtl/single_port_ram_ctrl_if.sv
// Command and response channels of the RAM sequencer, both valid/ready.
// The master modport is the upstream agent; the slave modport is the controller.
interface single_port_ram_ctrl_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8
);

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_wr;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   modport master (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/ram_ctrl_timer.sv
// Read-timeout counter: cleared outside the wait, counts while enabled,
// and flags expire once it has reached TIMEOUT-1.
module ram_ctrl_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int            CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expire = (count == LAST);

endmodule

// File: rtl/single_port_ram_ctrl.sv
// Issues queued write/read commands to a single-port RAM one at a time and
// returns read data (or a timeout error) on the response channel.
module single_port_ram_ctrl
   import single_port_ram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rstn,
   single_port_ram_ctrl_if.slave bus,
   output logic                  ram_en,
   output logic                  ram_wr_rd,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   input  logic                  ram_out_en
);

   state_t                state;
   state_t                state_nxt;

   logic                  en_nxt;
   logic                  wr_rd_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [DATA_WIDTH-1:0] din_nxt;

   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic                  rsp_err_q;
   logic                  valid_nxt;
   logic [DATA_WIDTH-1:0] rdata_nxt;
   logic                  err_nxt;

   logic                  timer_expire;

   // The counter is zero on entry to READ, so it reads k-1 in the k-th wait cycle.
   ram_ctrl_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rstn    (rstn),
      .clear   (state != READ),
      .enable  (state == READ),
      .expire  (timer_expire)
   );

   assign bus.cmd_ready = (state == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Every registered output holds unless the current state says otherwise.
   always_comb begin
      state_nxt = state;
      en_nxt    = ram_en;
      wr_rd_nxt = ram_wr_rd;
      addr_nxt  = ram_addr;
      din_nxt   = ram_data_in;
      valid_nxt = rsp_valid_q;
      rdata_nxt = rsp_rdata_q;
      err_nxt   = rsp_err_q;

      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               addr_nxt = bus.cmd_addr;
               din_nxt  = bus.cmd_wdata;
               en_nxt   = 1'b1;
               if (is_write(bus.cmd_wr)) begin
                  wr_rd_nxt = OP_WR;
                  state_nxt = WRITE;
               end else begin
                  wr_rd_nxt = OP_RD;
                  state_nxt = READ;
               end
            end
         end
         WRITE: begin
            en_nxt    = 1'b0;
            wr_rd_nxt = 1'b0;
            state_nxt = IDLE;
         end
         READ: begin
            // A strobe arriving on the timeout cycle still delivers its data.
            if (ram_out_en) begin
               rdata_nxt = ram_data_out;
               err_nxt   = 1'b0;
               valid_nxt = 1'b1;
               en_nxt    = 1'b0;
               state_nxt = RESP;
            end else if (timer_expire) begin
               rdata_nxt = '0;
               err_nxt   = 1'b1;
               valid_nxt = 1'b1;
               en_nxt    = 1'b0;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               valid_nxt = 1'b0;
               err_nxt   = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ram_en      <= 1'b0;
         ram_wr_rd   <= 1'b0;
         ram_addr    <= '0;
         ram_data_in <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         ram_en      <= en_nxt;
         ram_wr_rd   <= wr_rd_nxt;
         ram_addr    <= addr_nxt;
         ram_data_in <= din_nxt;
         rsp_valid_q <= valid_nxt;
         rsp_rdata_q <= rdata_nxt;
         rsp_err_q   <= err_nxt;
      end
   end

   rsp_hold_stable: assert property (
      @(posedge clk) disable iff (!rstn)
      (rsp_valid_q && !bus.rsp_ready) |=>
         (rsp_valid_q && $stable(rsp_rdata_q) && $stable(rsp_err_q))
   );

endmodule

// File: tb/tb_single_port_ram_ctrl.sv
// Bench for single_port_ram_ctrl: a latency-programmable RAM model plus a
// transaction-timing model that predicts every output on every cycle.
module tb_single_port_ram_ctrl;

   localparam int AW = 3;
   localparam int DW = 8;
   localparam int TO = 15;

   logic          clk  = 1'b0;
   logic          rstn = 1'b0;
   logic          ram_en;
   logic          ram_wr_rd;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data_in;
   logic [DW-1:0] ram_data_out;
   logic          ram_out_en;

   single_port_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   single_port_ram_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (TO)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .bus          (bus),
      .ram_en       (ram_en),
      .ram_wr_rd    (ram_wr_rd),
      .ram_addr     (ram_addr),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out),
      .ram_out_en   (ram_out_en)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int en_total = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_en === 1'b1) en_total <= en_total + 1;
   end

   // RAM model: out_en pulses in the ram_lat-th cycle of a read (ram_lat=0: never).
   logic [DW-1:0] mem [8] = '{default: '0};
   logic          oe_q    = 1'b0;
   logic [DW-1:0] dout_q  = '0;
   int            rd_run  = 0;
   int            ram_lat = 2;
   logic          spur    = 1'b0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         oe_q   <= 1'b0;
         rd_run <= 0;
      end else begin
         oe_q <= 1'b0;
         if (ram_en && !ram_wr_rd) begin
            rd_run <= rd_run + 1;
            if (ram_lat != 0 && rd_run + 1 == ram_lat - 1) begin
               oe_q   <= 1'b1;
               dout_q <= mem[ram_addr];
            end
         end else begin
            rd_run <= 0;
         end
         if (ram_en && ram_wr_rd) mem[ram_addr] <= ram_data_in;
      end
   end

   assign ram_out_en   = oe_q | spur;
   assign ram_data_out = spur ? 8'hEE : dout_q;

   // Timing model: edge_n counts rising edges; outputs are predicted from
   // edge indices of accept, RAM-enable window, response and handshake.
   logic [DW-1:0] mem_model [8] = '{default: '0};
   int            edge_n   = 0;
   int            idle_at  = 0;
   int            en_first = 1;
   int            en_last  = 0;
   int            rsp_at   = 0;
   int            k_rd     = 0;
   bit            pend     = 1'b0;
   bit            en_wr    = 1'b0;
   bit            lat_ok   = 1'b0;
   bit            acc      = 1'b0;
   bit            hs       = 1'b0;
   logic [AW-1:0] m_addr   = '0;
   logic [DW-1:0] m_din    = '0;
   logic [DW-1:0] m_rdata  = '0;
   logic [DW-1:0] new_data = '0;
   logic          new_err  = 1'b0;
   logic          m_err    = 1'b0;
   logic          m_valid  = 1'b0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend     = 1'b0;
         idle_at  = 0;
         en_first = 1;
         en_last  = 0;
         m_addr   = '0;
         m_din    = '0;
         m_rdata  = '0;
         m_err    = 1'b0;
         m_valid  = 1'b0;
      end else begin
         edge_n++;
         acc = !pend && (edge_n - 1 >= idle_at) && bus.cmd_valid;
         hs  = pend && (edge_n - 1 >= rsp_at) && bus.rsp_ready;
         if (hs) begin
            pend    = 1'b0;
            idle_at = edge_n;
         end
         if (acc) begin
            m_addr   = bus.cmd_addr;
            m_din    = bus.cmd_wdata;
            en_first = edge_n;
            if (bus.cmd_wr) begin
               en_wr   = 1'b1;
               en_last = edge_n;
               idle_at = edge_n + 1;
               mem_model[bus.cmd_addr] = bus.cmd_wdata;
            end else begin
               lat_ok   = (ram_lat >= 2) && (ram_lat <= TO);
               k_rd     = lat_ok ? ram_lat : TO;
               en_wr    = 1'b0;
               en_last  = edge_n + k_rd - 1;
               rsp_at   = edge_n + k_rd;
               pend     = 1'b1;
               new_data = lat_ok ? mem_model[bus.cmd_addr] : '0;
               new_err  = !lat_ok;
            end
         end
         if (pend && edge_n == rsp_at) begin
            m_rdata = new_data;
            m_err   = new_err;
         end
         if (!pend) m_err = 1'b0;
         m_valid = pend && (edge_n >= rsp_at);
      end
   end

   bit chk_on = 1'b0;
   bit en_exp;

   always @(negedge clk) begin
      if (chk_on) begin
         en_exp = (edge_n >= en_first) && (edge_n <= en_last);
         check_output("cmd_ready",   bus.cmd_ready, 32'(!pend && edge_n >= idle_at));
         check_output("ram_en",      ram_en,        32'(en_exp));
         check_output("ram_wr_rd",   ram_wr_rd,     32'(en_exp && en_wr));
         check_output("ram_addr",    ram_addr,      32'(m_addr));
         check_output("ram_data_in", ram_data_in,   32'(m_din));
         check_output("rsp_valid",   bus.rsp_valid, 32'(m_valid));
         check_output("rsp_rdata",   bus.rsp_rdata, 32'(m_rdata));
         check_output("rsp_err",     bus.rsp_err,   32'(m_err));
      end
   end

   task automatic apply_stimulus(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_wr    = wr;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      while (bus.cmd_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check_output("cmd_accept_wait", 32'(n), 32'd0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   // Waits for a response, optionally stalls it for `hold` cycles while poking
   // stray strobes and commands, then completes the handshake.
   task automatic wait_rsp(input int hold, input logic [DW-1:0] exp_d, input logic exp_e, output int lat);
      int n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check_output("rsp_wait", 32'(n), 32'd0);
      lat = n;
      check_output("rsp_data_lit", bus.rsp_rdata, 32'(exp_d));
      check_output("rsp_err_lit",  bus.rsp_err,   32'(exp_e));
      for (int i = 0; i < hold; i++) begin
         spur = (i == 1);
         if (i == 2) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_wr    = 1'b1;
            bus.cmd_addr  = 3'd7;
            bus.cmd_wdata = 8'hFF;
         end
         if (i == 4) bus.cmd_valid = 1'b0;
         @(negedge clk);
         check_output("hold_valid",     bus.rsp_valid, 32'd1);
         check_output("hold_rdata",     bus.rsp_rdata, 32'(exp_d));
         check_output("hold_cmd_ready", bus.cmd_ready, 32'd0);
      end
      spur          = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check_output("post_hs_valid",     bus.rsp_valid, 32'd0);
      check_output("post_hs_cmd_ready", bus.cmd_ready, 32'd1);
   endtask

   initial begin
      #100000;
      failures++;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat;
      int en0;
      int t_acc [4];
      int lats [4] = '{2, 3, 4, 2};
      bit saw;

      bus.cmd_valid = 1'b0;
      bus.cmd_wr    = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;

      repeat (3) @(negedge clk);
      check_output("rst_cmd_ready", bus.cmd_ready, 32'd1);
      check_output("rst_ram_en",    ram_en,        32'd0);
      check_output("rst_ram_addr",  ram_addr,      32'd0);
      check_output("rst_ram_din",   ram_data_in,   32'd0);
      check_output("rst_rsp_valid", bus.rsp_valid, 32'd0);
      check_output("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check_output("rst_rsp_err",   bus.rsp_err,   32'd0);
      rstn   = 1'b1;
      chk_on = 1'b1;
      @(negedge clk);

      $display("[TB] write A5 to 3, read it back");
      ram_lat = 2;
      apply_stimulus(1'b1, 3'd3, 8'hA5);
      check_output("wr_en_lit",    ram_en,    32'd1);
      check_output("wr_wr_rd_lit", ram_wr_rd, 32'd1);
      @(negedge clk);
      check_output("wr_en_drop", ram_en, 32'd0);
      apply_stimulus(1'b0, 3'd3, 8'h00);
      wait_rsp(0, 8'hA5, 1'b0, lat);
      check_output("rd_latency_min", 32'(lat), 32'd2);

      $display("[TB] read with no out_en strobe");
      ram_lat = 0;
      en0 = en_total;
      apply_stimulus(1'b0, 3'd5, 8'h00);
      wait_rsp(0, 8'h00, 1'b1, lat);
      check_output("timeout_en_cycles", 32'(en_total - en0), 32'd15);
      check_output("timeout_latency",   32'(lat),            32'd15);

      $display("[TB] stalled response");
      ram_lat = 3;
      apply_stimulus(1'b1, 3'd6, 8'h5A);
      apply_stimulus(1'b0, 3'd6, 8'h00);
      wait_rsp(5, 8'h5A, 1'b0, lat);
      check_output("stall_latency", 32'(lat), 32'd3);

      $display("[TB] back-to-back writes then readback");
      ram_lat = 2;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b1, AW'(i), DW'(8'h10 + i));
         t_acc[i] = cyc;
      end
      for (int i = 1; i < 4; i++) begin
         check_output("wr_spacing", 32'(t_acc[i] - t_acc[i-1]), 32'd2);
      end
      for (int i = 0; i < 4; i++) begin
         ram_lat = lats[i];
         apply_stimulus(1'b0, AW'(i), 8'h00);
         wait_rsp(0, DW'(8'h10 + i), 1'b0, lat);
         check_output("readback_latency", 32'(lat), 32'(lats[i]));
      end

      $display("[TB] reset during read wait");
      ram_lat = 0;
      apply_stimulus(1'b0, 3'd1, 8'h00);
      repeat (2) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check_output("midrst_ram_en",    ram_en,        32'd0);
      check_output("midrst_cmd_ready", bus.cmd_ready, 32'd1);
      check_output("midrst_rsp_valid", bus.rsp_valid, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      saw = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0) saw = 1'b1;
      end
      check_output("midrst_no_rsp", 32'(saw), 32'd0);
      ram_lat = 2;
      apply_stimulus(1'b0, 3'd2, 8'h00);
      wait_rsp(0, 8'h12, 1'b0, lat);
      check_output("post_rst_latency", 32'(lat), 32'd2);

      $display("[TB] strobe on the last wait cycle and one past it");
      ram_lat = 2;
      apply_stimulus(1'b1, 3'd4, 8'h3C);
      ram_lat = 15;
      apply_stimulus(1'b0, 3'd4, 8'h00);
      wait_rsp(0, 8'h3C, 1'b0, lat);
      check_output("edge_latency", 32'(lat), 32'd15);
      ram_lat = 16;
      apply_stimulus(1'b0, 3'd4, 8'h00);
      wait_rsp(0, 8'h00, 1'b1, lat);
      check_output("late_latency", 32'(lat), 32'd15);

      $display("[TB] stray strobe while idle");
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      @(negedge clk);
      check_output("idle_spur_en",    ram_en,        32'd0);
      check_output("idle_spur_valid", bus.rsp_valid, 32'd0);
      check_output("idle_spur_rdata", bus.rsp_rdata, 32'h00);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/single_port_ram_ctrl.md
Name: single_port_ram_ctrl

Overview:
Request sequencer that sits directly upstream of the single-port RAM and drives its en/wr_rd/addr/data_in pins.
- Accepts write/read commands on a valid/ready interface and issues them to the RAM one at a time.
- Waits for the RAM's out_en strobe on reads and returns read data on a valid/ready response interface.
- Guards each read with a timeout, so a missing out_en cannot hang the system.

Parameters:
ADDR_WIDTH, 3, RAM address width
DATA_WIDTH, 8, RAM data width
TIMEOUT, 15, max cycles spent in READ waiting for ram_out_en before an error response (must be >=2)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_wr  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  command address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  read response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_WIDTH  read data
rsp_err  out  1  1 = read timed out, rsp_rdata is 0
ram_en  out  1  to RAM en
ram_wr_rd  out  1  to RAM wr_rd (1=write)
ram_addr  out  ADDR_WIDTH  to RAM addr
ram_data_in  out  DATA_WIDTH  to RAM data_in
ram_data_out  in  DATA_WIDTH  from RAM data_out
ram_out_en  in  1  from RAM out_en, read data valid strobe

Behaviour:
Interface decision: one clock; reset is asynchronous and active-low (ports clk, rstn).

Reset (rstn low, asynchronous):
- State goes to IDLE.
- ram_en=0, ram_wr_rd=0, ram_addr=0, ram_data_in=0.
- rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.
- cmd_ready=1, since it is decoded from state==IDLE.
- An in-flight command or pending response is dropped with no response.

Output timing:
- All ram_* and rsp_* outputs are registered.
- cmd_ready is combinational: cmd_ready = (state==IDLE).

States:
- IDLE
  - cmd_valid&cmd_ready latches cmd_addr/cmd_wdata into ram_addr/ram_data_in.
  - cmd_wr=1 -> WRITE with ram_en=1, ram_wr_rd=1.
  - cmd_wr=0 -> READ with ram_en=1, ram_wr_rd=0, counter=0.
- WRITE
  - Exactly one cycle.
  - Next edge: ram_en=0, ram_wr_rd=0 -> IDLE.
  - Writes are posted and produce no response.
  - Peak write throughput is one write per 2 cycles.
- READ
  - ram_en=1 and ram_addr held stable; the counter increments each cycle.
  - ram_out_en=1 sampled: rsp_rdata<=ram_data_out, rsp_err<=0, rsp_valid<=1, ram_en<=0 -> RESP.
  - Else if counter==TIMEOUT-1: rsp_rdata<=0, rsp_err<=1, rsp_valid<=1, ram_en<=0 -> RESP.
  - If ram_out_en and timeout coincide, the data path wins (rsp_err=0).
- RESP
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1 is sampled.
  - On that edge: rsp_valid<=0, rsp_err<=0 -> IDLE.
  - rsp_rdata keeps its last value after the handshake.

Boundary conditions:
- ram_out_en in IDLE, WRITE or RESP is ignored.
- cmd_valid outside IDLE is not accepted; the upstream source must hold the command.
- ram_addr and ram_data_in hold their last values in IDLE.
- Read-to-response latency = RAM read latency + 1 cycle. Minimum command-to-rsp_valid is 2 cycles when out_en arrives 1 cycle after en.
- No address wrap logic is needed; the address is full-width and passed through.

Decomposition:
- Package single_port_ram_ctrl_pkg: state encoding constants IDLE=2'd0, WRITE=2'd1, READ=2'd2, RESP=2'd3; op constants OP_WR=1'b1, OP_RD=1'b0.
- One sub-module, ram_ctrl_timer: a $clog2(TIMEOUT)-bit counter with clear/enable inputs and an expire output at TIMEOUT-1, instantiated for the READ timeout.
- FSM and datapath registers stay in the top module.

Test Plan:
- Write addr=3 data=8'hA5, then read addr=3; RAM model with out_en 1 cycle after en -> ram_en high exactly 1 cycle with ram_wr_rd=1 for the write; rsp_valid with rsp_rdata=8'hA5, rsp_err=0, 2 cycles after the read is accepted.
- Read addr=5 with the RAM model never asserting out_en -> ram_en high for 15 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0; cmd_ready returns to 1 after the rsp_ready handshake.
- Read completes, then hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable throughout, cmd_ready=0; release -> IDLE on the next edge.
- cmd_valid held high with 4 writes to addr 0..3 -> one write accepted every 2 cycles; readback of each address returns its written value.
- rstn pulsed low mid-READ (cycle 3 of wait) -> ram_en=0 and cmd_ready=1 immediately, no rsp_valid ever produced; a following read works normally.
- RAM model asserts out_en exactly in READ cycle 15 (counter==14) with data 8'h3C -> rsp_rdata=8'h3C, rsp_err=0.
